// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master arbiter slice.
package apb_pkg;

    localparam int unsigned ADDRW_DEF = 32;
    localparam int unsigned DATAW_DEF = 32;

    localparam logic APB_READ  = 1'b0;
    localparam logic APB_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    logic [IW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IW'((32'(ptr) + i) % NREQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB3 master port among NREQ requesters with round-robin grant
// and a PREADY timeout that aborts the transfer with an error.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned ADDRW   = ADDRW_DEF,
    parameter int unsigned DATAW   = DATAW_DEF,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ*ADDRW-1:0] req_addr,
    input  logic [NREQ*DATAW-1:0] req_wdata,
    output logic [NREQ-1:0]       done,
    output logic [DATAW-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDRW-1:0]      PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATAW-1:0]      PWDATA,
    input  logic [DATAW-1:0]      PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT);

    apb_state_e      state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] gnt;

    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            win_valid;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (ptr),
        .grant       (win),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

    // Transfer sequencer; the winner's request is captured on IDLE exit and held to the end.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PADDR     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        gnt    <= win;
                        PADDR  <= req_addr[win_idx*ADDRW +: ADDRW];
                        PWRITE <= req_write[win_idx];
                        PWDATA <= req_wdata[win_idx*DATAW +: DATAW];
                        PSEL   <= 1'b1;
                        ptr    <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A late PREADY on the last allowed cycle still counts as a normal completion.
                    if (PREADY || (cnt == CW'(TIMEOUT-1))) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        done    <= gnt;
                        rsp_err <= PREADY ? PSLVERR : 1'b1;
                        if (PREADY && (PWRITE == APB_READ))
                            rsp_rdata <= PRDATA;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench: batch-level round-robin model, scripted APB slave, done monitor.
module tb_apb_master_arbiter;

    localparam int TMO = 16;

    logic         PCLK, PRESET;
    logic [3:0]   req_valid, req_write;
    logic [127:0] req_addr, req_wdata;
    logic [3:0]   done;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [31:0]  PADDR, PWDATA, PRDATA;
    logic         PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    apb_master_arbiter #(.ADDRW(32), .DATAW(32), .NREQ(4), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr, wdata, rdata, exp_rdata;
        logic        err;
        int          wt;
        bit          first;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t plan_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, setup_cyc = 0, last_done = 0;
    int m_ptr = 0;
    logic [31:0] m_rdata = '0;
    int b_wait[4];
    logic b_err[4];
    logic [31:0] b_rdata[4];

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int wt, input logic er, input logic [31:0] rd);
        req_write[i] = wr;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = d;
        b_wait[i] = wt;
        b_err[i] = er;
        b_rdata[i] = rd;
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return r % 4;
        if (r < 8) return $urandom_range(0, 6);
        if (r == 8) return TMO - 1;
        return TMO + 4;
    endfunction

    task automatic rand_all();
        for (int i = 0; i < 4; i++)
            set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, pick_wait(),
                    1'($urandom_range(0, 1)), $urandom);
    endtask

    // Grant order for a batch held steady from the start: repeated round-robin picks.
    task automatic plan_batch(input logic [3:0] mask);
        logic [3:0] pend;
        int w;
        bit first;
        xfer_t x;
        pend = mask;
        first = 1'b1;
        while (pend != 0) begin
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && pend[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            pend[w] = 1'b0;
            m_ptr = (w + 1) % 4;
            x.idx = w;
            x.wr = req_write[w];
            x.addr = req_addr[w*32 +: 32];
            x.wdata = req_wdata[w*32 +: 32];
            x.rdata = b_rdata[w];
            x.wt = b_wait[w];
            x.first = first;
            first = 1'b0;
            x.err = (x.wt >= TMO) ? 1'b1 : b_err[w];
            if (!x.wr && x.wt < TMO) m_rdata = x.rdata;
            x.exp_rdata = m_rdata;
            exp_q.push_back(x);
            plan_q.push_back(x);
        end
    endtask

    task automatic run_batch(input logic [3:0] mask);
        plan_batch(mask);
        @(negedge PCLK);
        start_cyc = cyc;
        req_valid = mask;
        for (int n = 0; n < 300 && req_valid != 0; n++) begin
            @(negedge PCLK);
            req_valid = req_valid & ~done;
            for (int i = 0; i < 4; i++)
                if (!req_valid[i]) begin
                    req_addr[i*32 +: 32] = $urandom;
                    req_wdata[i*32 +: 32] = $urandom;
                    req_write[i] = 1'($urandom_range(0, 1));
                end
        end
        check("batch_complete", 32'(req_valid), 32'(0));
        req_valid = '0;
        repeat (2) @(negedge PCLK);
    endtask

    // APB slave scripted by plan_q; PREADY is random whenever it must be ignored.
    initial begin : slave
        xfer_t cur;
        int wcnt;
        wcnt = 0;
        PREADY = 1'b1;
        PSLVERR = 1'b0;
        PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) begin
                setup_cyc = cyc;
                wcnt = 0;
                if (plan_q.size() == 0) begin
                    check("unexpected_setup", 32'(1), 32'(0));
                end else begin
                    cur = plan_q.pop_front();
                    check("paddr", PADDR, cur.addr);
                    check("pwrite", 32'(PWRITE), 32'(cur.wr));
                    check("pwdata", PWDATA, cur.wdata);
                    if (cur.first) check("setup_latency", 32'(setup_cyc - start_cyc), 32'(1));
                    else check("setup_spacing", 32'(setup_cyc - last_done), 32'(2));
                end
                PREADY = 1'($urandom_range(0, 1));
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA = $urandom;
            end else if (PSEL && PENABLE) begin
                check("paddr_stable", PADDR, cur.addr);
                if (wcnt == cur.wt) begin
                    PREADY = 1'b1;
                    PSLVERR = cur.err;
                    PRDATA = cur.rdata;
                end else begin
                    PREADY = 1'b0;
                    PSLVERR = 1'($urandom_range(0, 1));
                    PRDATA = $urandom;
                end
                wcnt++;
            end else begin
                PREADY = 1'($urandom_range(0, 1));
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA = $urandom;
            end
        end
    end

    // Completion monitor against the expected queue.
    initial begin : monitor
        xfer_t e;
        logic [3:0] prev_done;
        int lat;
        prev_done = '0;
        forever begin
            @(negedge PCLK);
            if (done != 0) begin
                check("done_single_cycle", 32'(prev_done), 32'(0));
                last_done = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    lat = ((e.wt >= TMO) ? TMO - 1 : e.wt) + 2;
                    check("done_onehot", 32'(done), 32'(1) << e.idx);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_rdata", rsp_rdata, e.exp_rdata);
                    check("done_latency", 32'(cyc - setup_cyc), 32'(lat));
                    check("psel_low_at_done", 32'({PSEL, PENABLE}), 32'(0));
                end
            end
            prev_done = done;
        end
    end

    initial begin : stim
        PRESET = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h0);
        repeat (3) @(negedge PCLK);
        check("rst_psel", 32'(PSEL), 32'(0));
        check("rst_penable", 32'(PENABLE), 32'(0));
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_done", 32'(done), 32'(0));
        check("rst_rdata", rsp_rdata, 32'h0);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);

        set_req(0, 1'b1, 32'h10, 32'hABCD, 0, 1'b0, 32'h0);
        run_batch(4'b0001);
        set_req(2, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hABCD);
        run_batch(4'b0100);
        rand_all();
        for (int i = 0; i < 4; i++) begin b_wait[i] = 0; b_err[i] = 1'b0; end
        run_batch(4'b1111);
        rand_all();
        set_req(1, 1'b0, 32'h44, 32'h0, 3, 1'b0, 32'h1234_5678);
        run_batch(4'b0010);
        rand_all();
        set_req(3, 1'b0, 32'h80, 32'h0, TMO + 10, 1'b0, 32'hDEAD_BEEF);
        set_req(0, 1'b1, 32'h84, 32'h5555, 0, 1'b1, 32'h0);
        run_batch(4'b1001);
        rand_all();
        set_req(2, 1'b0, 32'h88, 32'h0, TMO - 1, 1'b0, 32'hCAFE_F00D);
        run_batch(4'b0100);

        for (int b = 0; b < 40; b++) begin
            rand_all();
            run_batch(4'($urandom_range(1, 15)));
        end

        // Reset in the middle of an ACCESS phase.
        rand_all();
        for (int i = 0; i < 4; i++) b_wait[i] = 5;
        plan_batch(4'b1010);
        @(negedge PCLK);
        start_cyc = cyc;
        req_valid = 4'b1010;
        for (int n = 0; n < 20 && !PENABLE; n++) @(negedge PCLK);
        check("reached_access", 32'(PENABLE), 32'(1));
        #1 PRESET = 1'b1;
        #1;
        check("midrst_psel", 32'(PSEL), 32'(0));
        check("midrst_penable", 32'(PENABLE), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_paddr", PADDR, 32'h0);
        exp_q.delete();
        plan_q.delete();
        m_ptr = 0;
        m_rdata = '0;
        req_valid = '0;
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        rand_all();
        run_batch(4'b1111);

        for (int b = 0; b < 10; b++) begin
            rand_all();
            run_batch(4'($urandom_range(1, 15)));
        end
        repeat (4) @(negedge PCLK);
        check("exp_queue_drained", 32'(exp_q.size()), 32'(0));
        check("plan_queue_drained", 32'(plan_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
